// File: rtl/mm_bus_master.sv
// mm_bus_master: single-outstanding initiator for the 64-bit MM register bus.
// Each accepted host request becomes a one-cycle bus pulse. Every request,
// read or write, produces exactly one response. A read that gets no data
// within RD_TIMEOUT cycles is answered with an error after a quiet window.
module mm_bus_master #(
    parameter int ADDR_W     = 17,
    parameter int RD_TIMEOUT = 64,
    parameter int WR_GAP     = 1,
    parameter int QUIET_CYC  = 8,
    parameter int TO_CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [63:0]         req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_wr,
    output logic                rsp_err,
    output logic [63:0]         rsp_rdata,
    output logic                oMM_WR_EN,
    output logic                oMM_RD_EN,
    output logic [ADDR_W-1:0]   oMM_ADDR,
    output logic [63:0]         oMM_WR_DATA,
    input  logic [63:0]         iMM_RD_DATA,
    input  logic                iMM_RD_DATA_V,
    output logic                busy,
    output logic [TO_CNT_W-1:0] timeout_cnt
);

    // One shared counter times WR_HOLD, RD_WAIT and QUIET.
    localparam int MAX_A = (RD_TIMEOUT > QUIET_CYC) ? RD_TIMEOUT : QUIET_CYC;
    localparam int MAX_C = (MAX_A > WR_GAP) ? MAX_A : WR_GAP;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] Q_LAST  = CNT_W'(QUIET_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WR_HOLD, S_RD_WAIT, S_QUIET, S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         wdata_q, wdata_d;
    logic                rsp_wr_q, rsp_wr_d;
    logic                rsp_err_q, rsp_err_d;
    logic [63:0]         rsp_rdata_q, rsp_rdata_d;
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [31:0]         addr_ext;

    assign addr_ext = 32'(addr_q);

    // Gating with rst keeps req_ready low while reset is held even though
    // the state register already sits in IDLE.
    assign req_ready   = (state_q == S_IDLE) & ~rst;
    assign busy        = (state_q != S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_wr      = rsp_wr_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign oMM_WR_EN   = (state_q == S_ISSUE) & wr_q;
    assign oMM_RD_EN   = (state_q == S_ISSUE) & ~wr_q;
    assign oMM_ADDR    = addr_q;
    assign oMM_WR_DATA = wdata_q;
    assign timeout_cnt = to_cnt_q;

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // Next-state logic; response fields are loaded only on entry to RESP so
    // they stay stable while the host stalls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                if (wr_q) begin
                    if (WR_GAP == 0) begin
                        rsp_wr_d    = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_WR_HOLD;
                    end
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_WR_HOLD: begin
                if (cnt_q == WR_LAST) begin
                    rsp_wr_d    = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_WAIT: begin
                // Data on the last wait cycle still wins over expiry.
                if (iMM_RD_DATA_V) begin
                    rsp_wr_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = iMM_RD_DATA;
                    state_d     = S_RESP;
                end else if (cnt_q == RD_LAST) begin
                    if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 1'b1;
                    cnt_d   = '0;
                    state_d = S_QUIET;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_QUIET: begin
                // Late read-valids from the slow target are ignored here.
                if (cnt_q == Q_LAST) begin
                    rsp_wr_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = {32'hDEAD_BEEF, addr_ext};
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
